// File: rtl/multicycle_controller_pkg.sv
// Shared opcode-class constants and controller state encoding.
// No logic; constants only.
// Not applicable: no datapath or flow control here.
package multicycle_controller_pkg;

  // Instruction classes carried in the top three opcode bits
  localparam logic [2:0] MEM_CLS = 3'b000;
  localparam logic [2:0] LDR_CLS = 3'b001;
  localparam logic [2:0] AND_CLS = 3'b010;
  localparam logic [2:0] NOT_CLS = 3'b011;
  localparam logic [2:0] SHF_CLS = 3'b100;
  localparam logic [2:0] ADD_CLS = 3'b101;
  localparam logic [2:0] DIV_CLS = 3'b110;
  localparam logic [2:0] ILL_CLS = 3'b111;

  // Sub-op bit that selects stm (1) over ldm (0) in the memory class
  localparam int STORE_BIT_POS = 0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEM,
    ST_DIV,
    ST_WB,
    ST_TRAP
  } state_t;

endpackage

// File: rtl/inst_classifier.sv
// Decodes an opcode class into the control attributes the sequencer needs.
// Purely combinational, zero latency.
// No flow control; outputs follow inputs.
import multicycle_controller_pkg::*;

module inst_classifier (
  input  logic [2:0] op_class,
  input  logic       store_bit,
  output logic       is_mem,
  output logic       is_store,
  output logic       is_div,
  output logic       is_illegal,
  output logic       writes_reg
);

  // Class decode; only stores and trapped opcodes skip the register write
  always_comb begin
    is_mem     = (op_class == MEM_CLS);
    is_store   = is_mem && store_bit;
    is_div     = (op_class == DIV_CLS);
    is_illegal = (op_class == ILL_CLS);
    writes_reg = !is_illegal && !is_store;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control sequencer: fetch, decode, memory, divide, writeback, trap.
// ALU ops retire 2 cycles after accept; memory 2+W; divide 2+DIV_CYCLES.
// Accepts one instruction only in FETCH; stalls in MEM until mem_ack.
import multicycle_controller_pkg::*;

module multicycle_controller #(
  parameter int OPCODE_W   = 4,
  parameter int DIV_CYCLES = 8,
  parameter int SUB_W      = OPCODE_W - 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                instr_ready,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_signal_write,
  output logic                reg_signal_write,
  output logic                pc_en,
  output logic [2:0]          op_class,
  output logic [SUB_W-1:0]    op_sub,
  output logic                div_busy,
  output logic                halted
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t               state;
  logic [OPCODE_W-1:0]  ir;
  logic [CNT_W-1:0]     div_cnt;

  logic is_mem, is_store, is_div, is_illegal, writes_reg;

  assign op_class = ir[OPCODE_W-1 -: 3];
  assign op_sub   = ir[SUB_W-1:0];

  inst_classifier u_classifier (
    .op_class   (op_class),
    .store_bit  (op_sub[STORE_BIT_POS]),
    .is_mem     (is_mem),
    .is_store   (is_store),
    .is_div     (is_div),
    .is_illegal (is_illegal),
    .writes_reg (writes_reg)
  );

  // Sequencer: outputs are registered alongside the state they belong to,
  // so each branch sets the outputs for the state it is entering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_FETCH;
      ir               <= '0;
      div_cnt          <= '0;
      instr_ready      <= 1'b1;
      mem_req          <= 1'b0;
      mem_signal_write <= 1'b0;
      reg_signal_write <= 1'b0;
      pc_en            <= 1'b0;
      div_busy         <= 1'b0;
      halted           <= 1'b0;
    end else begin
      instr_ready      <= 1'b0;
      mem_req          <= 1'b0;
      mem_signal_write <= 1'b0;
      reg_signal_write <= 1'b0;
      pc_en            <= 1'b0;
      div_busy         <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (instr_valid) begin
            ir    <= opcode;
            state <= ST_DECODE;
          end else begin
            instr_ready <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (is_illegal) begin
            state  <= ST_TRAP;
            halted <= 1'b1;
          end else if (is_mem) begin
            state            <= ST_MEM;
            mem_req          <= 1'b1;
            mem_signal_write <= is_store;
          end else if (is_div) begin
            state    <= ST_DIV;
            div_busy <= 1'b1;
            div_cnt  <= DIV_LOAD;
          end else begin
            state            <= ST_WB;
            pc_en            <= 1'b1;
            reg_signal_write <= writes_reg;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            state            <= ST_WB;
            pc_en            <= 1'b1;
            reg_signal_write <= writes_reg;
          end else begin
            mem_req          <= 1'b1;
            mem_signal_write <= is_store;
          end
        end
        ST_DIV: begin
          // Counter only moves while nonzero, so it can never wrap
          if (div_cnt == '0) begin
            state            <= ST_WB;
            pc_en            <= 1'b1;
            reg_signal_write <= writes_reg;
          end else begin
            div_cnt  <= div_cnt - 1'b1;
            div_busy <= 1'b1;
          end
        end
        ST_WB: begin
          state       <= ST_FETCH;
          instr_ready <= 1'b1;
        end
        ST_TRAP: begin
          state <= ST_TRAP;
        end
        default: begin
          state       <= ST_FETCH;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for two controller configurations (4-bit/8-cycle, 6-bit/1-cycle).
// Expected writebacks are queued at issue and checked when pc_en pulses.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid_a [2];
  logic [5:0] opc [2];
  logic       mem_ack_a [2];
  logic       instr_ready_a [2];
  logic       mem_req_a [2];
  logic       mem_signal_write_a [2];
  logic       reg_signal_write_a [2];
  logic       pc_en_a [2];
  logic [2:0] op_class_a [2];
  logic       div_busy_a [2];
  logic       halted_a [2];
  logic [0:0] sub0;
  logic [2:0] sub1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         lat;
    logic       rw;
    logic [2:0] cls;
    logic [2:0] sub;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  multicycle_controller #(.OPCODE_W(4), .DIV_CYCLES(8)) dut0 (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid_a[0]), .opcode(opc[0][3:0]), .instr_ready(instr_ready_a[0]),
    .mem_ack(mem_ack_a[0]), .mem_req(mem_req_a[0]), .mem_signal_write(mem_signal_write_a[0]),
    .reg_signal_write(reg_signal_write_a[0]), .pc_en(pc_en_a[0]), .op_class(op_class_a[0]),
    .op_sub(sub0), .div_busy(div_busy_a[0]), .halted(halted_a[0])
  );

  multicycle_controller #(.OPCODE_W(6), .DIV_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid_a[1]), .opcode(opc[1]), .instr_ready(instr_ready_a[1]),
    .mem_ack(mem_ack_a[1]), .mem_req(mem_req_a[1]), .mem_signal_write(mem_signal_write_a[1]),
    .reg_signal_write(reg_signal_write_a[1]), .pc_en(pc_en_a[1]), .op_class(op_class_a[1]),
    .op_sub(sub1), .div_busy(div_busy_a[1]), .halted(halted_a[1])
  );

  function automatic logic [2:0] get_sub(input int c);
    return (c == 0) ? {2'b00, sub0} : sub1;
  endfunction

  function automatic logic [5:0] mk_op(input int c, input logic [2:0] cls, input logic [2:0] sub);
    return (c == 0) ? {2'b00, cls, sub[0]} : {cls, sub};
  endfunction

  function automatic int div_len(input int c);
    return (c == 0) ? 8 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input int c, input string tag);
    chk({tag, "_rdy"},   instr_ready_a[c], 1);
    chk({tag, "_req"},   mem_req_a[c], 0);
    chk({tag, "_memwr"}, mem_signal_write_a[c], 0);
    chk({tag, "_regwr"}, reg_signal_write_a[c], 0);
    chk({tag, "_pcen"},  pc_en_a[c], 0);
    chk({tag, "_div"},   div_busy_a[c], 0);
    chk({tag, "_halt"},  halted_a[c], 0);
  endtask

  // Issue one instruction in FETCH and follow it to writeback.
  // w: MEM cycles including the ack cycle; early_ack: pulse mem_ack in DECODE;
  // mid_valid: pulse instr_valid during the divide stall.
  task automatic run(input int c, input string name, input logic [2:0] cls, input logic [2:0] sub,
                     input int w, input bit early_ack, input bit mid_valid);
    exp_t e, x;
    int k, req_n, wr_n, div_n, rdy_n, both_n, cls_bad, dcy, e_req, e_wr, e_div, pulse_at;
    bit done;
    dcy      = div_len(c);
    e.cls    = cls;
    e.sub    = (c == 0) ? {2'b00, sub[0]} : sub;
    e.rw     = !(cls == 3'b000 && sub[0]);
    e.lat    = (cls == 3'b000) ? 2 + w : (cls == 3'b110) ? 2 + dcy : 2;
    e_req    = (cls == 3'b000) ? w : 0;
    e_wr     = (cls == 3'b000 && sub[0]) ? w : 0;
    e_div    = (cls == 3'b110) ? dcy : 0;
    pulse_at = (dcy > 2) ? 3 : 1;
    {req_n, wr_n, div_n, rdy_n, both_n, cls_bad} = '0;
    chk({name, "_accept_rdy"}, instr_ready_a[c], 1);
    instr_valid_a[c] = 1'b1;
    opc[c] = mk_op(c, cls, sub);
    sb.push_back(e);
    done = 1'b0;
    k = 0;
    while (!done && k < 60) begin
      step();
      k++;
      instr_valid_a[c] = 1'b0;
      mem_ack_a[c] = 1'b0;
      if (mem_req_a[c]) req_n++;
      if (mem_signal_write_a[c]) wr_n++;
      if (reg_signal_write_a[c] && mem_signal_write_a[c]) both_n++;
      if (instr_ready_a[c]) rdy_n++;
      if (op_class_a[c] !== e.cls || get_sub(c) !== e.sub) cls_bad++;
      if (div_busy_a[c]) begin
        div_n++;
        if (mid_valid && div_n == pulse_at) instr_valid_a[c] = 1'b1;
      end
      if (early_ack && k == 1) mem_ack_a[c] = 1'b1;
      if (mem_req_a[c] && req_n == w) mem_ack_a[c] = 1'b1;
      if (pc_en_a[c]) begin
        done = 1'b1;
        if (sb.size() > 0) begin
          x = sb.pop_front();
          chk({name, "_wb_cycle"}, k, x.lat);
          chk({name, "_wb_regwr"}, reg_signal_write_a[c], x.rw);
          chk({name, "_wb_class"}, op_class_a[c], x.cls);
          chk({name, "_wb_sub"}, get_sub(c), x.sub);
        end
      end
    end
    chk({name, "_wb_seen"}, done, 1);
    chk({name, "_sb_empty"}, sb.size(), 0);
    step();
    instr_valid_a[c] = 1'b0;
    mem_ack_a[c] = 1'b0;
    chk({name, "_rdy_after_wb"}, instr_ready_a[c], 1);
    chk({name, "_pcen_single"}, pc_en_a[c], 0);
    chk({name, "_req_cycles"}, req_n, e_req);
    chk({name, "_memwr_cycles"}, wr_n, e_wr);
    chk({name, "_div_cycles"}, div_n, e_div);
    chk({name, "_rdy_low_busy"}, rdy_n, 0);
    chk({name, "_wr_overlap"}, both_n, 0);
    chk({name, "_class_stable"}, cls_bad, 0);
  endtask

  // Illegal class: halted from cycle 2, sticky, blocks fetch; rst recovers.
  task automatic trap(input int c);
    int bad;
    bad = 0;
    chk("trap_accept_rdy", instr_ready_a[c], 1);
    instr_valid_a[c] = 1'b1;
    opc[c] = mk_op(c, 3'b111, 3'b000);
    step();
    chk("trap_halt_c1", halted_a[c], 0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (halted_a[c] !== 1'b1 || instr_ready_a[c] !== 1'b0 || pc_en_a[c] !== 1'b0
          || reg_signal_write_a[c] !== 1'b0) bad++;
    end
    chk("trap_sticky", bad, 0);
    instr_valid_a[c] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("trap_rst_halt", halted_a[c], 0);
    chk("trap_rst_rdy", instr_ready_a[c], 1);
  endtask

  // Reset partway through a stall: no writeback ever appears.
  task automatic abort(input int c, input string name, input logic [2:0] cls, input int at);
    int busy_n, k, bad;
    busy_n = 0;
    k = 0;
    bad = 0;
    instr_valid_a[c] = 1'b1;
    opc[c] = mk_op(c, cls, 3'b000);
    while (busy_n < at && k < 30) begin
      step();
      k++;
      instr_valid_a[c] = 1'b0;
      if (div_busy_a[c] || mem_req_a[c]) busy_n++;
      if (pc_en_a[c]) bad++;
    end
    chk({name, "_reached"}, busy_n, at);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle(c, name);
    for (int i = 0; i < 12; i++) begin
      step();
      if (pc_en_a[c] || reg_signal_write_a[c] || div_busy_a[c] || mem_req_a[c]) bad++;
    end
    chk({name, "_no_wb"}, bad, 0);
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      instr_valid_a[c] = 1'b0;
      mem_ack_a[c] = 1'b0;
      opc[c] = '0;
    end
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk_idle(c, "reset");
      chk("reset_class", op_class_a[c], 0);
      chk("reset_sub", get_sub(c), 0);
    end
    for (int c = 0; c < 2; c++) begin
      run(c, "add", 3'b101, 3'b000, 0, 1'b0, 1'b0);
      run(c, "ldm", 3'b000, 3'b000, 3, 1'b1, 1'b0);
      run(c, "stm", 3'b000, 3'b001, 1, 1'b0, 1'b0);
      run(c, "xor", 3'b011, 3'b111, 0, 1'b0, 1'b0);
      run(c, "div", 3'b110, 3'b000, 0, 1'b0, 1'b1);
      run(c, "shl", 3'b100, 3'b010, 0, 1'b0, 1'b0);
      trap(c);
      abort(c, "abort_div", 3'b110, (div_len(c) >= 4) ? 4 : div_len(c));
      abort(c, "abort_mem", 3'b000, 2);
      run(c, "ldr_after", 3'b001, 3'b001, 0, 1'b0, 1'b0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
